// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start from the requester,
// busy/done status and the registered result back from the adder.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first from operand shift registers,
// carry kept in a flop between bits, result assembled MSB-inward and held until the next job.

// Purpose: single-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module FullAdder1bit_Behavioral (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Purpose: start/busy/done controller around a bit-serial adder.
// Latency: done pulses WIDTH cycles after the accepting edge; one job per WIDTH+2 cycles.
// Backpressure: start is honoured only in IDLE; requests seen in RUN/DONE are dropped.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_adder_ctrl_if.slave io
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_nx;
   logic             c_ff;
   logic             fa_sum;
   logic             fa_cout;
   logic             last;

   FullAdder1bit_Behavioral u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (c_ff),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   always_comb begin
      s_nx            = s_sr >> 1;
      s_nx[WIDTH-1]   = fa_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (io.start) state_nx = RUN;
         RUN:     if (last)     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      io.busy = (state == RUN);
      io.done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         s_sr    <= '0;
         c_ff    <= 1'b0;
         cnt     <= '0;
         io.sum  <= '0;
         io.cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.start) begin
                  a_sr <= io.a;
                  b_sr <= io.b;
                  c_ff <= io.cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               s_sr <= s_nx;
               c_ff <= fa_cout;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  io.sum  <= s_nx;
                  io.cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
